// File: rtl/timer_pkg.sv
// Shared encodings and field widths for the timer bank: command opcodes,
// per-channel state, time-field widths and the preset range check.
package timer_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_DOWN    = 2'b00,
        OP_START_UP     = 2'b01,
        OP_PAUSE_TOGGLE = 2'b10,
        OP_CLEAR        = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DOWN   = 2'b01,
        ST_UP     = 2'b10,
        ST_PAUSED = 2'b11
    } ch_state_e;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    // A countdown preset is usable only if every field is a legal clock value.
    function automatic logic preset_ok(
        input logic [HR_W-1:0]  hr,
        input logic [MIN_W-1:0] mn,
        input logic [SEC_W-1:0] sc,
        input logic [HR_W-1:0]  max_hr
    );
        return (sc <= SEC_MAX) && (mn <= MIN_MAX) && (hr <= max_hr);
    endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Command port and per-channel status of the timer bank; the master issues
// commands, the slave (the bank) reports counts and one-cycle event pulses.
interface timer_bank_if #(
    parameter int NCH = 2
);
    import timer_pkg::*;

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic                 cmd_valid;
    logic [CH_W-1:0]      cmd_ch;
    logic [1:0]           cmd_op;
    logic [HR_W-1:0]      init_hr;
    logic [MIN_W-1:0]     init_min;
    logic [SEC_W-1:0]     init_sec;

    logic [NCH*HR_W-1:0]  hr_all;
    logic [NCH*MIN_W-1:0] min_all;
    logic [NCH*SEC_W-1:0] sec_all;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       paused;
    logic [NCH-1:0]       timer_done;
    logic [NCH-1:0]       stop_watch_done;
    logic                 cmd_err;

    modport master (
        output cmd_valid, cmd_ch, cmd_op, init_hr, init_min, init_sec,
        input  hr_all, min_all, sec_all, busy, paused, timer_done,
               stop_watch_done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_op, init_hr, init_min, init_sec,
        output hr_all, min_all, sec_all, busy, paused, timer_done,
               stop_watch_done, cmd_err
    );

endinterface

// File: rtl/timer_channel.sv
// One timer channel: countdown from a preset or stopwatch up to MAX_HR:59:59,
// with pause/resume. Commands arrive pre-validated and override the count step.
module timer_channel
    import timer_pkg::*;
#(
    parameter int MAX_HR = 23
) (
    input  logic             clk_1hz,
    input  logic             rst,
    input  logic             i_cmd_valid,
    input  cmd_op_e          i_cmd_op,
    input  logic [HR_W-1:0]  i_init_hr,
    input  logic [MIN_W-1:0] i_init_min,
    input  logic [SEC_W-1:0] i_init_sec,
    output logic [HR_W-1:0]  o_hr,
    output logic [MIN_W-1:0] o_min,
    output logic [SEC_W-1:0] o_sec,
    output logic             o_busy,
    output logic             o_paused,
    output logic             o_timer_done,
    output logic             o_sw_done
);

    localparam logic [HR_W-1:0] MAX_HR_V = HR_W'(MAX_HR);

    ch_state_e        r_state, w_state_nx;
    logic             r_dir_up, w_dir_up_nx;
    logic [HR_W-1:0]  r_hr, w_hr_nx;
    logic [MIN_W-1:0] r_min, w_min_nx;
    logic [SEC_W-1:0] r_sec, w_sec_nx;
    logic             r_timer_done, w_timer_done_nx;
    logic             r_sw_done, w_sw_done_nx;
    // A zero preset finishes immediately; its done pulse is deferred one edge.
    logic             r_zero_pend, w_zero_pend_nx;

    always_ff @(posedge clk_1hz) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_dir_up     <= 1'b0;
            r_hr         <= '0;
            r_min        <= '0;
            r_sec        <= '0;
            r_timer_done <= 1'b0;
            r_sw_done    <= 1'b0;
            r_zero_pend  <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register samples pre-edge values.
            r_state      <= w_state_nx;
            r_dir_up     <= w_dir_up_nx;
            r_hr         <= w_hr_nx;
            r_min        <= w_min_nx;
            r_sec        <= w_sec_nx;
            r_timer_done <= w_timer_done_nx;
            r_sw_done    <= w_sw_done_nx;
            r_zero_pend  <= w_zero_pend_nx;
        end
    end

    always_comb begin
        // NOTE: hold defaults first, so no branch below can leave a latch.
        w_state_nx      = r_state;
        w_dir_up_nx     = r_dir_up;
        w_hr_nx         = r_hr;
        w_min_nx        = r_min;
        w_sec_nx        = r_sec;
        w_timer_done_nx = r_zero_pend;
        w_sw_done_nx    = 1'b0;
        w_zero_pend_nx  = 1'b0;

        if (i_cmd_valid) begin
            case (i_cmd_op)
                OP_LOAD_DOWN: begin
                    w_hr_nx  = i_init_hr;
                    w_min_nx = i_init_min;
                    w_sec_nx = i_init_sec;
                    if ((i_init_hr == '0) && (i_init_min == '0) && (i_init_sec == '0)) begin
                        w_state_nx     = ST_IDLE;
                        w_zero_pend_nx = 1'b1;
                    end else begin
                        w_state_nx = ST_DOWN;
                    end
                end
                OP_START_UP: begin
                    w_hr_nx    = '0;
                    w_min_nx   = '0;
                    w_sec_nx   = '0;
                    w_state_nx = ST_UP;
                end
                OP_PAUSE_TOGGLE: begin
                    case (r_state)
                        ST_DOWN: begin
                            w_state_nx  = ST_PAUSED;
                            w_dir_up_nx = 1'b0;
                        end
                        ST_UP: begin
                            w_state_nx  = ST_PAUSED;
                            w_dir_up_nx = 1'b1;
                        end
                        ST_PAUSED: w_state_nx = r_dir_up ? ST_UP : ST_DOWN;
                        default: ;
                    endcase
                end
                default: begin
                    w_hr_nx    = '0;
                    w_min_nx   = '0;
                    w_sec_nx   = '0;
                    w_state_nx = ST_IDLE;
                end
            endcase
        end else begin
            case (r_state)
                ST_DOWN: begin
                    // DOWN never holds 00:00:00, so an hour borrow always has an hour to take.
                    if (r_sec != '0) begin
                        w_sec_nx = r_sec - 1'b1;
                    end else begin
                        w_sec_nx = SEC_MAX;
                        if (r_min != '0) begin
                            w_min_nx = r_min - 1'b1;
                        end else begin
                            w_min_nx = MIN_MAX;
                            w_hr_nx  = r_hr - 1'b1;
                        end
                    end
                    if ((w_hr_nx == '0) && (w_min_nx == '0) && (w_sec_nx == '0)) begin
                        w_state_nx      = ST_IDLE;
                        w_timer_done_nx = 1'b1;
                    end
                end
                ST_UP: begin
                    if (r_sec != SEC_MAX) begin
                        w_sec_nx = r_sec + 1'b1;
                    end else begin
                        w_sec_nx = '0;
                        if (r_min != MIN_MAX) begin
                            w_min_nx = r_min + 1'b1;
                        end else begin
                            w_min_nx = '0;
                            w_hr_nx  = r_hr + 1'b1;
                        end
                    end
                    if ((w_hr_nx == MAX_HR_V) && (w_min_nx == MIN_MAX) && (w_sec_nx == SEC_MAX)) begin
                        w_state_nx   = ST_IDLE;
                        w_sw_done_nx = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_hr         = r_hr;
    assign o_min        = r_min;
    assign o_sec        = r_sec;
    assign o_busy       = (r_state == ST_DOWN) || (r_state == ST_UP);
    assign o_paused     = (r_state == ST_PAUSED);
    assign o_timer_done = r_timer_done;
    assign o_sw_done    = r_sw_done;

endmodule

// File: rtl/timer_bank.sv
// Bank of NCH timer channels behind one command port. Validates each command,
// routes accepted ones to their channel and pulses cmd_err one edge after a rejection.
module timer_bank
    import timer_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int MAX_HR = 23
) (
    input  logic        clk_1hz,
    input  logic        rst,
    timer_bank_if.slave bus
);

    localparam logic [HR_W-1:0] MAX_HR_V = HR_W'(MAX_HR);

    cmd_op_e              w_op;
    logic                 w_ch_in_range;
    logic                 w_tgt_active;
    logic                 w_reject;
    logic [NCH-1:0]       w_ch_cmd;
    logic [NCH-1:0]       w_busy;
    logic [NCH-1:0]       w_paused;
    logic [NCH-1:0]       w_done;
    logic [NCH-1:0]       w_sw_done;
    logic [NCH*HR_W-1:0]  w_hr;
    logic [NCH*MIN_W-1:0] w_min;
    logic [NCH*SEC_W-1:0] w_sec;
    logic                 r_err_pend;
    logic                 r_cmd_err;

    assign w_op          = cmd_op_e'(bus.cmd_op);
    assign w_ch_in_range = (int'(bus.cmd_ch) < NCH);

    // Whether the addressed channel is running or paused; PAUSE_TOGGLE needs one of those.
    always_comb begin
        w_tgt_active = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(bus.cmd_ch) == i) begin
                w_tgt_active = w_busy[i] | w_paused[i];
            end
        end
    end

    always_comb begin
        w_reject = 1'b0;
        if (bus.cmd_valid) begin
            if (!w_ch_in_range) begin
                w_reject = 1'b1;
            end else begin
                case (w_op)
                    OP_LOAD_DOWN:
                        w_reject = !preset_ok(bus.init_hr, bus.init_min, bus.init_sec, MAX_HR_V);
                    OP_PAUSE_TOGGLE:
                        w_reject = !w_tgt_active;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_ch_cmd = '0;
        for (int i = 0; i < NCH; i++) begin
            w_ch_cmd[i] = bus.cmd_valid && !w_reject && (int'(bus.cmd_ch) == i);
        end
    end

    // The rejection is noted on the command edge and reported on the next one.
    always_ff @(posedge clk_1hz) begin
        if (rst) begin
            r_err_pend <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_err_pend <= w_reject;
            r_cmd_err  <= r_err_pend;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        timer_channel #(
            .MAX_HR (MAX_HR)
        ) u_channel (
            .clk_1hz      (clk_1hz),
            .rst          (rst),
            .i_cmd_valid  (w_ch_cmd[g]),
            .i_cmd_op     (w_op),
            .i_init_hr    (bus.init_hr),
            .i_init_min   (bus.init_min),
            .i_init_sec   (bus.init_sec),
            .o_hr         (w_hr[g*HR_W +: HR_W]),
            .o_min        (w_min[g*MIN_W +: MIN_W]),
            .o_sec        (w_sec[g*SEC_W +: SEC_W]),
            .o_busy       (w_busy[g]),
            .o_paused     (w_paused[g]),
            .o_timer_done (w_done[g]),
            .o_sw_done    (w_sw_done[g])
        );
    end

    assign bus.hr_all          = w_hr;
    assign bus.min_all         = w_min;
    assign bus.sec_all         = w_sec;
    assign bus.busy            = w_busy;
    assign bus.paused          = w_paused;
    assign bus.timer_done      = w_done;
    assign bus.stop_watch_done = w_sw_done;
    assign bus.cmd_err         = r_cmd_err;

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: two instances (3 ch / MAX_HR 23 and 2 ch / MAX_HR 0),
// a seconds-based reference model compared every cycle, and literal spot checks.
module tb_timer_bank;
    import timer_pkg::*;

    localparam int NCH_A   = 3;
    localparam int MAXHR_A = 23;
    localparam int NCH_B   = 2;
    localparam int MAXHR_B = 0;

    localparam int MD_IDLE   = 0;
    localparam int MD_DOWN   = 1;
    localparam int MD_UP     = 2;
    localparam int MD_PAUSED = 3;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    timer_bank_if #(.NCH(NCH_A)) bus_a ();
    timer_bank_if #(.NCH(NCH_B)) bus_b ();

    timer_bank #(.NCH(NCH_A), .MAX_HR(MAXHR_A)) u_dut_a (
        .clk_1hz (clk),
        .rst     (rst_a),
        .bus     (bus_a.slave)
    );

    timer_bank #(.NCH(NCH_B), .MAX_HR(MAXHR_B)) u_dut_b (
        .clk_1hz (clk),
        .rst     (rst_b),
        .bus     (bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: count kept as total seconds ----------------
    int m_mode  [2][3];
    int m_dir_up[2][3];
    int m_secs  [2][3];
    int m_td    [2][3];
    int m_sw    [2][3];
    int m_zp    [2][3];
    int m_errp  [2];
    int m_err   [2];

    function automatic int nch_of(input int d);
        return (d == 0) ? NCH_A : NCH_B;
    endfunction

    function automatic int maxhr_of(input int d);
        return (d == 0) ? MAXHR_A : MAXHR_B;
    endfunction

    task automatic model_step(input int d, input int r, input int v, input int ch,
                              input int op, input int h, input int mi, input int s);
        int acc;
        if (r != 0) begin
            for (int c = 0; c < 3; c++) begin
                m_mode[d][c] = MD_IDLE; m_dir_up[d][c] = 0; m_secs[d][c] = 0;
                m_td[d][c] = 0; m_sw[d][c] = 0; m_zp[d][c] = 0;
            end
            m_errp[d] = 0;
            m_err[d]  = 0;
        end else begin
            m_err[d]  = m_errp[d];
            m_errp[d] = 0;
            acc = 0;
            if (v != 0) begin
                if (ch >= nch_of(d)) m_errp[d] = 1;
                else if (op == 0 && (s > 59 || mi > 59 || h > maxhr_of(d))) m_errp[d] = 1;
                else if (op == 2 && m_mode[d][ch] == MD_IDLE) m_errp[d] = 1;
                else acc = 1;
            end
            for (int c = 0; c < nch_of(d); c++) begin
                m_td[d][c] = m_zp[d][c];
                m_zp[d][c] = 0;
                m_sw[d][c] = 0;
                if (acc != 0 && ch == c) begin
                    case (op)
                        0: begin
                            m_secs[d][c] = h * 3600 + mi * 60 + s;
                            if (m_secs[d][c] == 0) begin
                                m_mode[d][c] = MD_IDLE;
                                m_zp[d][c]   = 1;
                            end else begin
                                m_mode[d][c] = MD_DOWN;
                            end
                        end
                        1: begin m_secs[d][c] = 0; m_mode[d][c] = MD_UP; end
                        2: begin
                            if (m_mode[d][c] == MD_PAUSED) begin
                                m_mode[d][c] = (m_dir_up[d][c] != 0) ? MD_UP : MD_DOWN;
                            end else begin
                                m_dir_up[d][c] = (m_mode[d][c] == MD_UP) ? 1 : 0;
                                m_mode[d][c]   = MD_PAUSED;
                            end
                        end
                        default: begin m_secs[d][c] = 0; m_mode[d][c] = MD_IDLE; end
                    endcase
                end else if (m_mode[d][c] == MD_DOWN) begin
                    m_secs[d][c]--;
                    if (m_secs[d][c] == 0) begin m_mode[d][c] = MD_IDLE; m_td[d][c] = 1; end
                end else if (m_mode[d][c] == MD_UP) begin
                    m_secs[d][c]++;
                    if (m_secs[d][c] == maxhr_of(d) * 3600 + 3599) begin
                        m_mode[d][c] = MD_IDLE;
                        m_sw[d][c]   = 1;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, int'(rst_a), int'(bus_a.cmd_valid), int'(bus_a.cmd_ch), int'(bus_a.cmd_op),
                   int'(bus_a.init_hr), int'(bus_a.init_min), int'(bus_a.init_sec));
        model_step(1, int'(rst_b), int'(bus_b.cmd_valid), int'(bus_b.cmd_ch), int'(bus_b.cmd_op),
                   int'(bus_b.init_hr), int'(bus_b.init_min), int'(bus_b.init_sec));
    end

    task automatic cmp_ch(input int d, input int c, input int hr, input int mn, input int sc,
                          input int bz, input int pz, input int td, input int sw);
        int t;
        t = m_secs[d][c];
        check($sformatf("d%0d.ch%0d.hr", d, c), hr, t / 3600);
        check($sformatf("d%0d.ch%0d.min", d, c), mn, (t / 60) % 60);
        check($sformatf("d%0d.ch%0d.sec", d, c), sc, t % 60);
        check($sformatf("d%0d.ch%0d.busy", d, c), bz,
              (m_mode[d][c] == MD_DOWN || m_mode[d][c] == MD_UP) ? 1 : 0);
        check($sformatf("d%0d.ch%0d.paused", d, c), pz, (m_mode[d][c] == MD_PAUSED) ? 1 : 0);
        check($sformatf("d%0d.ch%0d.timer_done", d, c), td, m_td[d][c]);
        check($sformatf("d%0d.ch%0d.sw_done", d, c), sw, m_sw[d][c]);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int c = 0; c < NCH_A; c++) begin
                cmp_ch(0, c, int'(bus_a.hr_all[c*5 +: 5]), int'(bus_a.min_all[c*6 +: 6]),
                       int'(bus_a.sec_all[c*6 +: 6]), int'(bus_a.busy[c]), int'(bus_a.paused[c]),
                       int'(bus_a.timer_done[c]), int'(bus_a.stop_watch_done[c]));
            end
            check("d0.cmd_err", int'(bus_a.cmd_err), m_err[0]);
            for (int c = 0; c < NCH_B; c++) begin
                cmp_ch(1, c, int'(bus_b.hr_all[c*5 +: 5]), int'(bus_b.min_all[c*6 +: 6]),
                       int'(bus_b.sec_all[c*6 +: 6]), int'(bus_b.busy[c]), int'(bus_b.paused[c]),
                       int'(bus_b.timer_done[c]), int'(bus_b.stop_watch_done[c]));
            end
            check("d1.cmd_err", int'(bus_b.cmd_err), m_err[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic int a_hr(input int c);  return int'(bus_a.hr_all[c*5 +: 5]);  endfunction
    function automatic int a_min(input int c); return int'(bus_a.min_all[c*6 +: 6]); endfunction
    function automatic int a_sec(input int c); return int'(bus_a.sec_all[c*6 +: 6]); endfunction

    task automatic cmd_a(input int ch, input int op, input int h, input int mi, input int s);
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_ch    = 2'(ch);
        bus_a.cmd_op    = 2'(op);
        bus_a.init_hr   = 5'(h);
        bus_a.init_min  = 6'(mi);
        bus_a.init_sec  = 6'(s);
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
    endtask

    task automatic cmd_b(input int ch, input int op, input int h, input int mi, input int s);
        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_ch    = 1'(ch);
        bus_b.cmd_op    = 2'(op);
        bus_b.init_hr   = 5'(h);
        bus_b.init_min  = 6'(mi);
        bus_b.init_sec  = 6'(s);
        @(negedge clk);
        bus_b.cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        bus_a.cmd_valid = 1'b0; bus_a.cmd_ch = '0; bus_a.cmd_op = '0;
        bus_a.init_hr = '0; bus_a.init_min = '0; bus_a.init_sec = '0;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_ch = '0; bus_b.cmd_op = '0;
        bus_b.init_hr = '0; bus_b.init_min = '0; bus_b.init_sec = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst.busy", int'(bus_a.busy), 0);
        check("rst.paused", int'(bus_a.paused), 0);
        check("rst.sec_all", int'(bus_a.sec_all), 0);
        check("rst.cmd_err", int'(bus_a.cmd_err), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // Countdown of five seconds.
        cmd_a(0, OP_LOAD_DOWN, 0, 0, 5);
        check("ld5.sec_loaded", a_sec(0), 5);
        check("ld5.busy", int'(bus_a.busy[0]), 1);
        for (int i = 4; i >= 0; i--) begin
            @(negedge clk);
            check("ld5.sec_step", a_sec(0), i);
        end
        check("ld5.timer_done", int'(bus_a.timer_done[0]), 1);
        check("ld5.busy_end", int'(bus_a.busy[0]), 0);
        @(negedge clk);
        check("ld5.done_one_cycle", int'(bus_a.timer_done[0]), 0);

        // Minute and hour borrows.
        cmd_a(0, OP_LOAD_DOWN, 0, 1, 0);
        @(negedge clk);
        check("borrow_min.min", a_min(0), 0);
        check("borrow_min.sec", a_sec(0), 59);
        cmd_a(0, OP_LOAD_DOWN, 1, 0, 0);
        @(negedge clk);
        check("borrow_hr.hr", a_hr(0), 0);
        check("borrow_hr.min", a_min(0), 59);
        check("borrow_hr.sec", a_sec(0), 59);
        cmd_a(0, OP_CLEAR, 0, 0, 0);

        // Pause while another channel keeps counting up.
        cmd_a(1, OP_START_UP, 0, 0, 0);
        cmd_a(0, OP_LOAD_DOWN, 0, 0, 10);
        cmd_a(0, OP_PAUSE_TOGGLE, 0, 0, 0);
        check("pause.paused", int'(bus_a.paused[0]), 1);
        check("pause.sec", a_sec(0), 10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pause.frozen", a_sec(0), 10);
        end
        cmd_a(0, OP_PAUSE_TOGGLE, 0, 0, 0);
        check("resume.busy", int'(bus_a.busy[0]), 1);
        @(negedge clk);
        check("resume.sec", a_sec(0), 9);
        check("pause.ch1_sec", a_sec(1), 7);

        // Rejected commands.
        cmd_a(0, OP_LOAD_DOWN, 0, 0, 60);
        check("bad_sec.err_not_yet", int'(bus_a.cmd_err), 0);
        check("bad_sec.still_counting", a_sec(0), 8);
        @(negedge clk);
        check("bad_sec.err", int'(bus_a.cmd_err), 1);
        check("bad_sec.unchanged", a_sec(0), 7);
        @(negedge clk);
        check("bad_sec.err_one_cycle", int'(bus_a.cmd_err), 0);
        cmd_a(0, OP_LOAD_DOWN, 0, 60, 0);
        cmd_a(0, OP_LOAD_DOWN, 24, 0, 0);
        cmd_a(3, OP_CLEAR, 0, 0, 0);
        cmd_a(0, OP_CLEAR, 0, 0, 0);
        cmd_a(1, OP_CLEAR, 0, 0, 0);
        cmd_a(2, OP_PAUSE_TOGGLE, 0, 0, 0);
        check("idle_pause.err_not_yet", int'(bus_a.cmd_err), 0);
        @(negedge clk);
        check("idle_pause.err", int'(bus_a.cmd_err), 1);
        check("clear.busy_all", int'(bus_a.busy), 0);

        // Zero preset: done one edge later, channel idle.
        cmd_a(2, OP_LOAD_DOWN, 0, 0, 0);
        check("zero.busy", int'(bus_a.busy[2]), 0);
        check("zero.done_not_yet", int'(bus_a.timer_done[2]), 0);
        @(negedge clk);
        check("zero.done", int'(bus_a.timer_done[2]), 1);
        @(negedge clk);
        check("zero.done_one_cycle", int'(bus_a.timer_done[2]), 0);

        // Stopwatch carry; command on one channel leaves another counting.
        cmd_a(2, OP_START_UP, 0, 0, 0);
        repeat (60) @(negedge clk);
        cmd_a(0, OP_LOAD_DOWN, 0, 0, 5);
        check("carry.min", a_min(2), 1);
        check("carry.sec", a_sec(2), 1);
        cmd_a(2, OP_START_UP, 0, 0, 0);
        check("restart.sec", a_sec(2), 0);
        check("restart.min", a_min(2), 0);

        // Reset in mid-countdown, together with a command.
        @(negedge clk);
        check("pre_rst.sec", a_sec(0), 3);
        rst_a = 1'b1;
        cmd_a(1, OP_START_UP, 0, 0, 0);
        rst_a = 1'b0;
        check("rst_mid.sec", a_sec(0), 0);
        check("rst_mid.busy", int'(bus_a.busy), 0);
        check("rst_mid.done", int'(bus_a.timer_done[0]), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid.no_done", int'(bus_a.timer_done[0]), 0);
        end

        // Stopwatch saturation with MAX_HR = 0 on the second instance.
        cmd_b(0, OP_LOAD_DOWN, 1, 0, 0);
        @(negedge clk);
        check("b.bad_hr.err", int'(bus_b.cmd_err), 1);
        cmd_b(1, OP_START_UP, 0, 0, 0);
        seen = 0;
        for (int i = 0; i < 3700 && seen == 0; i++) begin
            @(negedge clk);
            if (bus_b.stop_watch_done[1]) seen = 1;
        end
        check("b.sw_done_seen", seen, 1);
        check("b.sw.hr", int'(bus_b.hr_all[9:5]), 0);
        check("b.sw.min", int'(bus_b.min_all[11:6]), 59);
        check("b.sw.sec", int'(bus_b.sec_all[11:6]), 59);
        check("b.sw.busy", int'(bus_b.busy[1]), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b.sw.once", int'(bus_b.stop_watch_done[1]), 0);
            check("b.sw.held", int'(bus_b.sec_all[11:6]), 59);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
